// File: rtl/urg_pkg.sv
// rtl/urg_pkg.sv - shared constants and state type for the uniform range generator
package urg_pkg;

    localparam logic [30:0] LFSR_TAPS = 31'h4800_0000;
    localparam logic [30:0] SEED_DEF  = 31'b0010110110100011000111111101010;
    localparam int          REJ_CNT_W = 16;

    typedef enum logic [1:0] {
        CALC,
        DRAW,
        VALID
    } urg_state_e;

endpackage

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Fibonacci LFSR with loadable seed
// An all-zero seed would lock the register, so it is replaced by SEED_DEF.
module lfsr_gen #(
    parameter int                LFSR_W   = 31,
    parameter logic [LFSR_W-1:0] TAPS     = urg_pkg::LFSR_TAPS,
    parameter logic [LFSR_W-1:0] SEED_DEF = urg_pkg::SEED_DEF
) (
    input  logic              qzt_clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;
    logic              fb;

    assign fb = ^(state_q & TAPS);

    always_comb begin
        state_d = {state_q[LFSR_W-2:0], fb};
        if (load) begin
            state_d = (seed == '0) ? SEED_DEF : seed;
        end
    end

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            state_q <= SEED_DEF;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/uniform_range_gen.sv
// rtl/uniform_range_gen.sv - uniform draws in [0, N-1] from a shared LFSR
// Multiply-shift mapping; unbiased mode rejects samples whose low product bits fall below 2^SAMPLE_W mod N.
module uniform_range_gen
    import urg_pkg::*;
#(
    parameter int                LFSR_W   = 31,
    parameter int                SAMPLE_W = 10,
    parameter int                OUT_W    = 4,
    parameter logic [LFSR_W-1:0] SEED_DEF = urg_pkg::SEED_DEF
) (
    input  logic                 qzt_clk,
    input  logic                 reset,
    input  logic                 seed_load,
    input  logic [LFSR_W-1:0]    seed,
    input  logic [OUT_W-1:0]     range_n,
    input  logic                 mode,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [OUT_W-1:0]     out_value,
    output logic                 range_err,
    output logic [REJ_CNT_W-1:0] reject_cnt
);

    localparam int CNT_W = $clog2(SAMPLE_W + 1);
    localparam int M_W   = SAMPLE_W + OUT_W;

    logic [LFSR_W-1:0]    lfsr;
    logic                 lfsr_unused;
    logic [SAMPLE_W-1:0]  sample;
    logic [M_W-1:0]       m;
    logic [OUT_W:0]       rem_shift;
    logic                 div_bit;
    logic                 range_chg;

    urg_state_e           state_q, state_d;
    logic [OUT_W-1:0]     n_q, n_d;
    logic [OUT_W-1:0]     rem_q, rem_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SAMPLE_W-1:0]  thr_q, thr_d;
    logic                 valid_q, valid_d;
    logic [OUT_W-1:0]     value_q, value_d;
    logic                 err_q, err_d;
    logic [REJ_CNT_W-1:0] rej_q, rej_d;

    lfsr_gen #(
        .LFSR_W   (LFSR_W),
        .TAPS     (LFSR_W'(LFSR_TAPS)),
        .SEED_DEF (SEED_DEF)
    ) u_lfsr (
        .qzt_clk (qzt_clk),
        .reset   (reset),
        .load    (seed_load),
        .seed    (seed),
        .state   (lfsr)
    );

    assign lfsr_unused = ^lfsr;
    assign sample      = lfsr[SAMPLE_W-1:0] ^ lfsr[LFSR_W-1 -: SAMPLE_W];
    assign m           = M_W'(sample) * M_W'(n_q);
    assign range_chg   = (range_n != n_q);

    // Dividend 2^SAMPLE_W is a one followed by SAMPLE_W zeros, fed MSB first.
    assign div_bit   = (cnt_q == '0);
    assign rem_shift = {rem_q, div_bit};

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        thr_d   = thr_q;
        valid_d = valid_q;
        value_d = value_q;
        rej_d   = rej_q;
        err_d   = (range_n == '0);

        if (range_chg) begin
            n_d     = range_n;
            state_d = CALC;
            cnt_d   = '0;
            rem_d   = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                CALC: begin
                    if (n_q != '0) begin
                        if (rem_shift >= {1'b0, n_q}) begin
                            rem_d = OUT_W'(rem_shift - {1'b0, n_q});
                        end else begin
                            rem_d = OUT_W'(rem_shift);
                        end
                        if (cnt_q == CNT_W'(SAMPLE_W)) begin
                            thr_d   = {{(SAMPLE_W-OUT_W){1'b0}}, rem_d};
                            state_d = DRAW;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DRAW: begin
                    if (mode || (m[SAMPLE_W-1:0] >= thr_q)) begin
                        value_d = m[M_W-1:SAMPLE_W];
                        valid_d = 1'b1;
                        state_d = VALID;
                    end else if (rej_q != '1) begin
                        rej_d = rej_q + REJ_CNT_W'(1);
                    end
                end
                VALID: begin
                    if (out_ready) begin
                        valid_d = 1'b0;
                        state_d = DRAW;
                    end
                end
                default: state_d = CALC;
            endcase
        end
    end

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            state_q <= CALC;
            n_q     <= range_n;
            rem_q   <= '0;
            cnt_q   <= '0;
            thr_q   <= '0;
            valid_q <= 1'b0;
            value_q <= '0;
            err_q   <= 1'b0;
            rej_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            thr_q   <= thr_d;
            valid_q <= valid_d;
            value_q <= value_d;
            err_q   <= err_d;
            rej_q   <= rej_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_value  = value_q;
    assign range_err  = err_q;
    assign reject_cnt = rej_q;

endmodule

// File: tb/tb_uniform_range_gen.sv
// tb/tb_uniform_range_gen.sv - scoreboard bench for uniform_range_gen
module tb_uniform_range_gen;

    localparam int          SAMPLE_W = 10;
    localparam int          SPAN     = 1 << SAMPLE_W;
    localparam logic [30:0] SEED     = 31'b0010110110100011000111111101010;

    logic        qzt_clk = 1'b0;
    logic        reset;
    logic        seed_load;
    logic [30:0] seed;
    logic [3:0]  range_n;
    logic        mode;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  out_value;
    logic        range_err;
    logic [15:0] reject_cnt;

    int checks = 0;
    int errors = 0;

    always #5 qzt_clk = ~qzt_clk;

    uniform_range_gen #(
        .LFSR_W   (31),
        .SAMPLE_W (SAMPLE_W),
        .OUT_W    (4)
    ) dut (
        .qzt_clk    (qzt_clk),
        .reset      (reset),
        .seed_load  (seed_load),
        .seed       (seed),
        .range_n    (range_n),
        .mode       (mode),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_value  (out_value),
        .range_err  (range_err),
        .reject_cnt (reject_cnt)
    );

    typedef enum {M_CALC, M_DRAW, M_VALID} m_state_e;
    m_state_e    m_state = M_CALC;
    logic [30:0] m_lfsr  = SEED;
    int          m_n = 0, m_cnt = 0, m_thr = 0, m_rej = 0;
    logic        m_valid = 1'b0, m_err = 1'b0;

    int exp_q[$];
    int got_q[$];
    int hist[16];
    int hs_cnt = 0;
    int nonzero_n1 = 0;
    bit mon_en = 1'b0;
    int ref_seq[8], seq_a[8], seq_b[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: arithmetic form of the draw, stepped once per clock.
    always @(posedge qzt_clk) begin
        int samp, prod;
        if (reset) begin
            m_lfsr  = SEED;
            m_state = M_CALC;
            m_n     = int'(range_n);
            m_cnt   = 0;
            m_valid = 1'b0;
            m_rej   = 0;
            m_err   = 1'b0;
            exp_q.delete();
        end else begin
            samp = int'(m_lfsr[9:0] ^ m_lfsr[30:21]);
            if (int'(range_n) != m_n) begin
                if (m_valid && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
                m_valid = 1'b0;
                m_n     = int'(range_n);
                m_state = M_CALC;
                m_cnt   = 0;
            end else begin
                case (m_state)
                    M_CALC: if (m_n != 0) begin
                        if (m_cnt == SAMPLE_W) begin
                            m_thr   = SPAN % m_n;
                            m_state = M_DRAW;
                        end else begin
                            m_cnt++;
                        end
                    end
                    M_DRAW: begin
                        prod = samp * m_n;
                        if (mode || (prod % SPAN) >= m_thr) begin
                            m_valid = 1'b1;
                            exp_q.push_back(prod / SPAN);
                            m_state = M_VALID;
                        end else if (m_rej != 16'hFFFF) begin
                            m_rej++;
                        end
                    end
                    M_VALID: if (out_ready) begin
                        m_valid = 1'b0;
                        m_state = M_DRAW;
                    end
                    default: m_state = M_CALC;
                endcase
            end
            m_err = (range_n == 4'd0);
            if (seed_load) m_lfsr = (seed == 31'd0) ? SEED : seed;
            else           m_lfsr = {m_lfsr[29:0], m_lfsr[30] ^ m_lfsr[27]};
        end
    end

    always @(negedge qzt_clk) begin
        if (mon_en) begin
            check("out_valid", int'(out_valid), int'(m_valid));
            check("range_err", int'(range_err), int'(m_err));
            check("reject_cnt", int'(reject_cnt), m_rej);
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: out_value %0d, expected no value", out_value);
                end else if (int'(out_value) != exp_q[0]) begin
                    errors++;
                    $display("FAIL out_value: got %0d, expected %0d", out_value, exp_q[0]);
                end
                checks++;
                if (int'(out_value) >= m_n) begin
                    errors++;
                    $display("FAIL value_range: got %0d, required below %0d", out_value, m_n);
                end
                if (out_ready && !reset && int'(range_n) == m_n) begin
                    if (exp_q.size() > 0) exp_q.pop_front();
                    got_q.push_back(int'(out_value));
                    hist[out_value]++;
                    hs_cnt++;
                    if (m_n == 1 && out_value != 4'd0) nonzero_n1++;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge qzt_clk);
            #2;
        end
    endtask

    task automatic wait_got(input int n, input string name);
        int cyc = 0;
        while (got_q.size() < n && cyc < 4000) begin
            step(1);
            cyc++;
        end
        checks++;
        if (got_q.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d values, required %0d", name, got_q.size(), n);
        end
    endtask

    task automatic seeded_run(input logic [30:0] s);
        range_n   = 4'd10;
        mode      = 1'b0;
        out_ready = 1'b1;
        reset     = 1'b1;
        step(1);
        reset     = 1'b0;
        seed_load = 1'b1;
        seed      = s;
        got_q.delete();
        step(1);
        seed_load = 1'b0;
        wait_got(8, "seeded");
    endtask

    initial begin
        int edges, cyc, rej_snap;
        reset     = 1'b1;
        seed_load = 1'b0;
        seed      = 31'd0;
        range_n   = 4'd10;
        mode      = 1'b0;
        out_ready = 1'b1;
        step(2);
        mon_en = 1'b1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_value", int'(out_value), 0);
        check("reset_range_err", int'(range_err), 0);
        check("reset_reject_cnt", int'(reject_cnt), 0);

        // Reset release, first draw latency and reference sequence
        reset = 1'b0;
        got_q.delete();
        edges = 0;
        while (!out_valid && edges < 100) begin
            step(1);
            edges++;
        end
        checks++;
        if (edges < SAMPLE_W + 2 || edges >= 100) begin
            errors++;
            $display("FAIL first_valid_edge: got %0d edges after release, required %0d..99", edges, SAMPLE_W + 2);
        end
        wait_got(8, "first_draws");
        for (int i = 0; i < 8; i++) ref_seq[i] = got_q[i];

        // Distribution over N = 10
        for (int i = 0; i < 16; i++) hist[i] = 0;
        hs_cnt = 0;
        cyc = 0;
        while (hs_cnt < 3000 && cyc < 30000) begin
            step(1);
            cyc++;
        end
        check("uniform_draw_count", int'(hs_cnt >= 3000), 1);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (hist[i] < 200 || hist[i] > 400) begin
                errors++;
                $display("FAIL bin_%0d: got %0d, required 200..400", i, hist[i]);
            end
        end
        for (int i = 10; i < 16; i++) check($sformatf("bin_%0d_empty", i), hist[i], 0);

        // Backpressure, then range change with a simultaneous handshake
        out_ready = 1'b0;
        step(50);
        check("stall_valid", int'(out_valid), 1);
        range_n   = 4'd7;
        out_ready = 1'b1;
        step(1);
        check("change_drops_valid", int'(out_valid), 0);
        for (int i = 0; i < 11; i++) begin
            step(1);
            check("calc_no_valid", int'(out_valid), 0);
        end
        got_q.delete();
        wait_got(20, "n7_draws");

        // N = 0
        range_n = 4'd0;
        hs_cnt  = 0;
        step(30);
        check("n0_range_err", int'(range_err), 1);
        check("n0_no_valid", int'(out_valid), 0);
        check("n0_no_draws", hs_cnt, 0);

        // N = 1
        range_n = 4'd1;
        step(15);
        got_q.delete();
        nonzero_n1 = 0;
        wait_got(20, "n1_draws");
        check("n1_all_zero", nonzero_n1, 0);

        // N = 8: power of two, no rejection
        range_n = 4'd8;
        step(15);
        rej_snap = m_rej;
        step(200);
        check("n8_no_reject", int'(reject_cnt), rej_snap);

        // N = 15 fast mode: one value every two cycles
        range_n = 4'd15;
        mode    = 1'b1;
        step(15);
        hs_cnt = 0;
        step(40);
        check("fast_throughput", hs_cnt, 20);
        mode = 1'b0;

        // Seeding
        seeded_run(31'd0);
        for (int i = 0; i < 8; i++) seq_a[i] = got_q[i];
        seeded_run(SEED);
        for (int i = 0; i < 8; i++) seq_b[i] = got_q[i];
        for (int i = 0; i < 8; i++) check($sformatf("seed0_vs_def_%0d", i), seq_a[i], seq_b[i]);
        seeded_run(31'h1234567);
        for (int i = 0; i < 8; i++) seq_a[i] = got_q[i];
        seeded_run(31'h1234567);
        for (int i = 0; i < 8; i++) check($sformatf("reseed_repeat_%0d", i), got_q[i], seq_a[i]);

        // Reset while a value is waiting
        range_n   = 4'd10;
        out_ready = 1'b0;
        step(40);
        check("pre_reset_valid", int'(out_valid), 1);
        reset = 1'b1;
        step(1);
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_reject_cnt", int'(reject_cnt), 0);
        reset     = 1'b0;
        out_ready = 1'b1;
        got_q.delete();
        wait_got(8, "restart_draws");
        for (int i = 0; i < 8; i++) check($sformatf("restart_seq_%0d", i), got_q[i], ref_seq[i]);

        step(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
